// File: rtl/mux_seq_pkg.sv
// Shared types and helpers for the 4:1 mux select sequencer.
package mux_seq_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SCAN
  } seq_state_e;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    lowest_set = '0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (m[i-1]) lowest_set = SEL_W'(i - 1);
    end
  endfunction

endpackage

// File: rtl/mux_seq_next_ch.sv
// Combinational round-robin search for the next enabled channel after cur_ch.
module mux_seq_next_ch
  import mux_seq_pkg::*;
(
  input  logic [SEL_W-1:0]  cur_ch,
  input  logic [NUM_CH-1:0] mask,
  output logic [SEL_W-1:0]  nxt_ch,
  output logic              wrap,
  output logic              none
);

  logic             found;
  logic [SEL_W-1:0] idx;

  // Candidates are cur+1, cur+2, cur+3 and finally cur itself.
  always_comb begin
    nxt_ch = cur_ch;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      idx = cur_ch + SEL_W'(i);
      if (!found && mask[idx]) begin
        nxt_ch = idx;
        found  = 1'b1;
      end
    end
    none = (mask == '0);
    wrap = !none && (nxt_ch <= cur_ch);
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Round-robin S1/S0 select generator with per-channel dwell and output snapshot.
// Optional build macro MUX_SEQ_CHANGE_EN adds the 'change' output.
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int unsigned DWELL = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] mask,
  input  logic              hold,
  input  logic              mux_o,
  output logic              S1,
  output logic              S0,
  output logic              sel_valid,
  output logic [NUM_CH-1:0] snap,
  output logic              scan_done
`ifdef MUX_SEQ_CHANGE_EN
  ,
  output logic              change
`endif
);

  seq_state_e        state_q, state_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] snap_q, snap_d;
  logic              done_d;
  logic              sample;

  logic [SEL_W-1:0]  nxt_ch;
  logic              nxt_wrap;
  logic              nxt_none;

  mux_seq_next_ch u_next_ch (
    .cur_ch (ch_q),
    .mask   (mask),
    .nxt_ch (nxt_ch),
    .wrap   (nxt_wrap),
    .none   (nxt_none)
  );

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    done_d  = 1'b0;
    sample  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && (mask != '0)) state_d = LOAD;
      end
      LOAD: begin
        if (!en || (mask == '0)) begin
          state_d = IDLE;
        end else begin
          ch_d    = lowest_set(mask);
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!en) begin
          state_d = IDLE;
        end else if (!hold) begin
          if (cnt_q == CNT_W'(DWELL - 1)) begin
            sample         = 1'b1;
            snap_d[ch_q]   = mux_o;
            cnt_d          = '0;
            // An empty mask still lets the final sample land before idling.
            if (nxt_none) begin
              state_d = IDLE;
            end else begin
              ch_d   = nxt_ch;
              done_d = nxt_wrap;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    sel_d = (state_d == SCAN) ? ch_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      snap_q    <= '0;
      sel_valid <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      sel_valid <= (state_d == SCAN);
      scan_done <= done_d;
    end
  end

  assign S1   = sel_q[1];
  assign S0   = sel_q[0];
  assign snap = snap_q;

`ifdef MUX_SEQ_CHANGE_EN
  logic seen_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      seen_q <= 1'b0;
      change <= 1'b0;
    end else begin
      change <= sample && seen_q && (mux_o != snap_q[ch_q]);
      if (sample) seen_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Randomized scoreboard bench for mux_sel_sequencer against a dwell-countdown model.
module tb_mux_sel_sequencer;

  localparam int unsigned DW = 4;

  logic       clk = 1'b0;
  logic       rst, en, hold;
  logic [3:0] mask;
  logic [3:0] ival;
  logic       mux_o;
  logic       S1, S0, sel_valid, scan_done;
  logic [3:0] snap;
  logic       change_o;

  always #5 clk = ~clk;

  assign mux_o = ival[{S1, S0}];

  mux_sel_sequencer #(.DWELL(DW), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mask      (mask),
    .hold      (hold),
    .mux_o     (mux_o),
    .S1        (S1),
    .S0        (S0),
    .sel_valid (sel_valid),
    .snap      (snap),
    .scan_done (scan_done)
`ifdef MUX_SEQ_CHANGE_EN
    ,
    .change    (change_o)
`endif
  );

`ifndef MUX_SEQ_CHANGE_EN
  assign change_o = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] sel;
    logic       sv;
    logic [3:0] snap;
    logic       done;
    logic       chg;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_pushed = 0;

  // Reference model: 0=idle, 1=about to pick first channel, 2=scanning.
  int       m_mode = 0;
  int       m_ch = 0;
  int       m_left = 0;
  bit [3:0] m_snap = '0;
  bit       m_seen = 0;

  task automatic apply(input bit r, input bit e, input bit [3:0] m, input bit h, input bit [3:0] iv);
    exp_t x;
    bit   old;
    rst = r; en = e; mask = m; hold = h; ival = iv;
    x = '0;
    if (r) begin
      m_mode = 0; m_ch = 0; m_left = 0; m_snap = '0; m_seen = 0;
    end else if (m_mode == 0) begin
      if (e && m != 0) m_mode = 1;
    end else if (!e || (m_mode == 1 && m == 0)) begin
      m_mode = 0;
    end else if (m_mode == 1) begin
      m_ch = 0;
      while (!m[m_ch]) m_ch++;
      m_left = DW;
      m_mode = 2;
    end else if (!h) begin
      m_left--;
      if (m_left == 0) begin
        old = m_snap[m_ch];
        m_snap[m_ch] = iv[m_ch];
        x.chg = m_seen && (old != iv[m_ch]);
        m_seen = 1;
        m_left = DW;
        if (m == 0) begin
          m_mode = 0;
        end else begin
          int k = 1;
          while (!m[(m_ch + k) % 4]) k++;
          x.done = ((m_ch + k) % 4) <= m_ch;
          m_ch = (m_ch + k) % 4;
        end
      end
    end
    x.sv   = (m_mode == 2);
    x.sel  = x.sv ? 2'(m_ch) : 2'b00;
    x.snap = m_snap;
`ifndef MUX_SEQ_CHANGE_EN
    x.chg = 1'b0;
`endif
    exp_q.push_back(x);
    n_pushed++;
  endtask

  task automatic check(input string name, input int cyc, input logic [3:0] got, input logic [3:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s cycle %0d got %b expected %b", name, cyc, got, want);
  endtask

  localparam int NCYC = 620;

  initial begin
    bit [3:0] m, iv;
    fork
      begin : stim
        apply(1, 1, 4'b1111, 0, 4'b1010);
        @(negedge clk) apply(1, 1, 4'b1111, 0, 4'b1010);
        for (int i = 0; i < 70; i++) @(negedge clk) apply(0, 1, 4'b1111, 0, 4'b1010);
        for (int i = 0; i < 50; i++) @(negedge clk) apply(0, 1, 4'b0101, 0, 4'b1010);
        for (int i = 0; i < 30; i++) @(negedge clk) apply(0, 1, 4'b0101, (i >= 10 && i < 15), 4'b1010);
        for (int i = 0; i < 10; i++) @(negedge clk) apply(0, 1, 4'b0001, 0, 4'b0000);
        for (int i = 0; i < 10; i++) @(negedge clk) apply(0, 1, 4'b0001, 0, 4'b0001);
        m = 4'b1011; iv = 4'b0110;
        while (n_pushed < NCYC) begin
          @(negedge clk);
          if ($urandom_range(0, 5) == 0) m = 4'($urandom_range(0, 15));
          if ($urandom_range(0, 7) == 0) iv = 4'($urandom_range(0, 15));
          apply($urandom_range(0, 79) == 0, $urandom_range(0, 19) != 0, m,
                $urandom_range(0, 5) == 0, iv);
        end
      end
      begin : mon
        exp_t x;
        for (int c = 0; c < NCYC; c++) begin
          @(posedge clk);
          #1;
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL queue cycle %0d got empty expected entry", c);
          end else begin
            x = exp_q.pop_front();
            check("sel", c, {2'b00, S1, S0}, {2'b00, x.sel});
            check("sel_valid", c, {3'b000, sel_valid}, {3'b000, x.sv});
            check("snap", c, snap, x.snap);
            check("scan_done", c, {3'b000, scan_done}, {3'b000, x.done});
`ifdef MUX_SEQ_CHANGE_EN
            check("change", c, {3'b000, change_o}, {3'b000, x.chg});
`endif
          end
        end
      end
    join
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
